ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It is the other direction of the existing keyboard receive path, used to send commands such as 0xFF (reset) and 0xED (set LEDs) to the keyboard. It accepts one byte over a valid/ready handshake and drives the open-drain PS/2 clock/data lines through the request-to-send sequence. Returns completion and ACK status. Lives in the clk_vga domain beside KeyBoardController; the top level muxes oe outputs onto the pads.

Parameters:
INHIBIT_CYCLES, 5000, cycles clock is held low before start bit (100 us @ 50 MHz)
TIMEOUT_CYCLES, 1000000, max cycles between device clock falling edges (20 ms @ 50 MHz)
FILTER_LEN, 8, consecutive equal samples required to accept a new filtered line level

Ports:
clk  in  1  system clock (clk_vga, 50 MHz)
reset_n  in  1  asynchronous active-low reset
tx_data  in  8  command byte; held stable while tx_valid=1 and not yet accepted
tx_valid  in  1  byte available
tx_ready  out  1  block idle; transfer accepted when tx_valid & tx_ready
ps2_clock  in  1  raw PS/2 clock pad level
ps2_data  in  1  raw PS/2 data pad level
ps2_clock_oe  out  1  1 = pull clock line low; 0 = release
ps2_data_oe  out  1  1 = pull data line low; 0 = release
busy  out  1  transfer in progress (= ~tx_ready)
done  out  1  one-cycle pulse at end of a completed transfer
ack_ok  out  1  valid with done: 1 = device ACK seen
error  out  1  one-cycle pulse on NACK or timeout

Behaviour:
- Reset (async, reset_n=0): ps2_clock_oe=0, ps2_data_oe=0, tx_ready=1, busy=0, done=0, ack_ok=0, error=0, FSM=IDLE. Lines are released immediately, independent of clk.
- Input conditioning: 2-FF synchroniser per line, then filter. Filtered level changes only after FILTER_LEN identical synchronised samples. Filtered reset value is 1. "Falling edge" means filtered clock goes 1->0.
- Parity: odd. parity = ~^tx_data, latched at accept.
- FSM:
  - IDLE: tx_ready=1. On accept, latch byte and parity; next cycle tx_ready=0, ps2_clock_oe=1, go INHIBIT.
  - INHIBIT: count INHIBIT_CYCLES cycles. On the last cycle set ps2_data_oe=1 (start bit). The following cycle set ps2_clock_oe=0, clear edge counter, go XFER.
  - XFER: on falling edge n (n=1..8), ps2_data_oe = ~tx_data[n-1] (LSB first). On edge 9, ps2_data_oe = ~parity. On edge 10, ps2_data_oe=0 (stop bit). On edge 11, sample filtered data: 0 = ACK, 1 = NACK. Then go WAIT_IDLE.
  - WAIT_IDLE: wait for filtered clock=1 and data=1. Then pulse done for 1 cycle with ack_ok = ACK result. On NACK, pulse error in the same cycle. Return to IDLE; tx_ready=1 the next cycle.
- Timeout: counter runs in XFER and WAIT_IDLE and clears on each falling edge. On reaching TIMEOUT_CYCLES: both oe=0, pulse error and done with ack_ok=0, go IDLE.
- tx_valid while busy is ignored. tx_data is sampled only at accept.
- ack_ok holds its value until the next done.
- Reset mid-transfer: abort with no done or error pulse.

Optional Feature:
PS2_HOST_TX_RETRY_EN:
- Defined: on NACK or timeout, the same latched byte is resent from INHIBIT, up to 2 retries (3 attempts total). done, ack_ok and error are reported only for the final attempt. error pulses only if all attempts fail. busy stays 1 across retries.
- Undefined: a single attempt; failure is reported immediately as above.

Test Plan:
- INHIBIT_CYCLES=50. Send 0xED; device model clocks and ACKs -> data pad bits observed 0(start),1,0,1,1,0,1,1,1, parity 1, stop 1; done pulse with ack_ok=1; error=0.
- Send 0xFF -> parity bit 1; ps2_clock_oe=1 for exactly 50 cycles before ps2_data_oe rises, then released 1 cycle later; tx_ready=0 from the cycle after accept until after done.
- Device leaves data high at edge 11 (NACK) -> done with ack_ok=0 and error pulse in the same cycle (macro off). With macro on: NACK, NACK, ACK -> single done with ack_ok=1, no error.
- TIMEOUT_CYCLES=1000, device never clocks -> error and done (ack_ok=0) exactly 1000 cycles after entering XFER; both oe=0; tx_ready=1 next cycle.
- Assert reset_n low after edge 4 -> both oe drop to 0 without waiting for clk; no done/error; new byte accepted after release.
- FILTER_LEN=8: 3-cycle low glitch on ps2_clock during XFER -> no bit advance; the following real edge drives the expected next bit.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Accepts one byte on a valid/ready handshake, runs the request-to-send
// sequence on the open-drain clock/data pads and reports ACK/NACK/timeout.
// Optional build macro PS2_HOST_TX_RETRY_EN: a failed byte is resent up to
// two more times before the failure is reported.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int FILTER_LEN     = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clock,
   input  logic       ps2_data,
   output logic       ps2_clock_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_ok,
   output logic       error
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int FLT_W = $clog2(FILTER_LEN + 1);

   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [INH_W-1:0] INH_END  = INH_W'(INHIBIT_CYCLES);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_XFER,
      ST_WAIT_IDLE
   } state_t;

   // ------------------------------------------------------------------
   // Input conditioning: index 0 = clock line, index 1 = data line.
   // ------------------------------------------------------------------
   logic [1:0] line_raw;
   logic [1:0] line_filt;

   assign line_raw = {ps2_data, ps2_clock};

   for (genvar gi = 0; gi < 2; gi++) begin : g_line
      logic             sync1_q;
      logic             sync2_q;
      logic             filt_q;
      logic             filt_d;
      logic [FLT_W-1:0] run_q;
      logic [FLT_W-1:0] run_d;

      // Accept a new level only after FILTER_LEN consecutive disagreeing samples
      always_comb begin
         run_d  = '0;
         filt_d = filt_q;
         if (sync2_q != filt_q) begin
            if (run_q == FLT_LAST) begin
               filt_d = sync2_q;
            end else begin
               run_d = run_q + 1'b1;
            end
         end
      end

      // Two-stage synchroniser and filter state; idle bus level is high
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            run_q   <= '0;
         end else begin
            sync1_q <= line_raw[gi];
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            run_q   <= run_d;
         end
      end

      assign line_filt[gi] = filt_q;
   end

   // ------------------------------------------------------------------
   // Transfer sequencer
   // ------------------------------------------------------------------
   state_t           state_q,     state_d;
   logic [INH_W-1:0] inh_q,       inh_d;
   logic [TO_W-1:0]  to_q,        to_d;
   logic [3:0]       edge_q,      edge_d;
   logic [7:0]       byte_q,      byte_d;
   logic             parity_q,    parity_d;
   logic             ack_res_q,   ack_res_d;
   logic             clk_prev_q,  clk_prev_d;
   logic             tx_ready_q,  tx_ready_d;
   logic             clock_oe_q,  clock_oe_d;
   logic             data_oe_q,   data_oe_d;
   logic             done_q,      done_d;
   logic             ack_ok_q,    ack_ok_d;
   logic             error_q,     error_d;
`ifdef PS2_HOST_TX_RETRY_EN
   logic [1:0]       attempt_q,   attempt_d;
`endif

   logic clk_fall;
   logic end_ok;
   logic end_fail;
   logic retry_ok;

   assign clk_fall = clk_prev_q & ~line_filt[0];

`ifdef PS2_HOST_TX_RETRY_EN
   assign retry_ok = (attempt_q != 2'd2);
`else
   assign retry_ok = 1'b0;
`endif

   // Next-state and next-output computation for the whole transfer
   always_comb begin
      state_d    = state_q;
      inh_d      = inh_q;
      to_d       = to_q;
      edge_d     = edge_q;
      byte_d     = byte_q;
      parity_d   = parity_q;
      ack_res_d  = ack_res_q;
      clk_prev_d = line_filt[0];
      tx_ready_d = tx_ready_q;
      clock_oe_d = clock_oe_q;
      data_oe_d  = data_oe_q;
      done_d     = 1'b0;
      ack_ok_d   = ack_ok_q;
      error_d    = 1'b0;
      end_ok     = 1'b0;
      end_fail   = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      attempt_d  = attempt_q;
`endif

      case (state_q)
         ST_IDLE: begin
            tx_ready_d = 1'b1;
            clock_oe_d = 1'b0;
            data_oe_d  = 1'b0;
            if (tx_valid && tx_ready_q) begin
               byte_d     = tx_data;
               parity_d   = ~^tx_data;
               tx_ready_d = 1'b0;
               clock_oe_d = 1'b1;
               inh_d      = '0;
               state_d    = ST_INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
               attempt_d  = 2'd0;
`endif
            end
         end

         ST_INHIBIT: begin
            // Clock held low; start bit goes out on the last inhibit cycle and
            // the clock is released one cycle later so the device sees data first.
            if (inh_q == INH_END) begin
               clock_oe_d = 1'b0;
               edge_d     = '0;
               to_d       = '0;
               state_d    = ST_XFER;
            end else begin
               if (inh_q == INH_LAST) begin
                  data_oe_d = 1'b1;
               end
               inh_d = inh_q + 1'b1;
            end
         end

         ST_XFER: begin
            if (clk_fall) begin
               to_d   = '0;
               edge_d = edge_q + 1'b1;
               if (edge_q < 4'd8) begin
                  data_oe_d = ~byte_q[edge_q[2:0]];
               end else if (edge_q == 4'd8) begin
                  data_oe_d = ~parity_q;
               end else if (edge_q == 4'd9) begin
                  data_oe_d = 1'b0;
               end else begin
                  // Eleventh edge: device pulls data low to acknowledge
                  ack_res_d = ~line_filt[1];
                  state_d   = ST_WAIT_IDLE;
               end
            end else if (to_q == TO_LAST) begin
               end_fail = 1'b1;
            end else begin
               to_d = to_q + 1'b1;
            end
         end

         ST_WAIT_IDLE: begin
            if (line_filt == 2'b11) begin
               end_ok   = ack_res_q;
               end_fail = ~ack_res_q;
            end else if (clk_fall) begin
               to_d = '0;
            end else if (to_q == TO_LAST) begin
               end_fail = 1'b1;
            end else begin
               to_d = to_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Attempt finished: either go round again or report and release the bus
      if (end_ok || end_fail) begin
         if (end_fail && retry_ok) begin
            clock_oe_d = 1'b1;
            data_oe_d  = 1'b0;
            inh_d      = '0;
            state_d    = ST_INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
            attempt_d  = attempt_q + 1'b1;
`endif
         end else begin
            clock_oe_d = 1'b0;
            data_oe_d  = 1'b0;
            done_d     = 1'b1;
            ack_ok_d   = end_ok;
            error_d    = end_fail;
            state_d    = ST_IDLE;
         end
      end
   end

   // All sequencer state and registered outputs; reset releases the pads at once
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         inh_q      <= '0;
         to_q       <= '0;
         edge_q     <= '0;
         byte_q     <= '0;
         parity_q   <= 1'b0;
         ack_res_q  <= 1'b0;
         clk_prev_q <= 1'b1;
         tx_ready_q <= 1'b1;
         clock_oe_q <= 1'b0;
         data_oe_q  <= 1'b0;
         done_q     <= 1'b0;
         ack_ok_q   <= 1'b0;
         error_q    <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
         attempt_q  <= 2'd0;
`endif
      end else begin
         state_q    <= state_d;
         inh_q      <= inh_d;
         to_q       <= to_d;
         edge_q     <= edge_d;
         byte_q     <= byte_d;
         parity_q   <= parity_d;
         ack_res_q  <= ack_res_d;
         clk_prev_q <= clk_prev_d;
         tx_ready_q <= tx_ready_d;
         clock_oe_q <= clock_oe_d;
         data_oe_q  <= data_oe_d;
         done_q     <= done_d;
         ack_ok_q   <= ack_ok_d;
         error_q    <= error_d;
`ifdef PS2_HOST_TX_RETRY_EN
         attempt_q  <= attempt_d;
`endif
      end
   end

   assign tx_ready     = tx_ready_q;
   assign busy         = ~tx_ready_q;
   assign ps2_clock_oe = clock_oe_q;
   assign ps2_data_oe  = data_oe_q;
   assign done         = done_q;
   assign ack_ok       = ack_ok_q;
   assign error        = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed tests of ps2_host_tx against a simple PS/2 device model.
// Frames are packed {stop, parity, data[7:0], start} as seen on the data pad.
`timescale 1ns/1ps
module tb_ps2_host_tx;
   localparam int INH  = 50;
   localparam int TO   = 1000;
   localparam int HALF = 40;

   logic       clk      = 1'b0;
   logic       reset_n  = 1'b0;
   logic [7:0] tx_data  = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       ps2_clock;
   logic       ps2_data;
   logic       ps2_clock_oe;
   logic       ps2_data_oe;
   logic       busy;
   logic       done;
   logic       ack_ok;
   logic       error;

   logic dev_clk_low  = 1'b0;
   logic dev_data_low = 1'b0;

   int   checks   = 0;
   int   passes   = 0;
   int   done_cnt = 0;
   int   err_cnt  = 0;
   logic done_ack = 1'b0;
   logic done_err = 1'b0;

   // open-drain wiring: either side may pull a line low
   assign ps2_clock = ~(ps2_clock_oe | dev_clk_low);
   assign ps2_data  = ~(ps2_data_oe  | dev_data_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TO),
      .FILTER_LEN(8)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .ps2_clock(ps2_clock),
      .ps2_data(ps2_data),
      .ps2_clock_oe(ps2_clock_oe),
      .ps2_data_oe(ps2_data_oe),
      .busy(busy),
      .done(done),
      .ack_ok(ack_ok),
      .error(error)
   );

   always #5 clk = ~clk;

   // record completion pulses
   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt++;
         done_ack = ack_ok;
         done_err = error;
      end
      if (error === 1'b1) err_cnt++;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b, output bit ok);
      int n;
      @(negedge clk);
      tx_data  = b;
      tx_valid = 1'b1;
      n = 0;
      while (tx_ready !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = ~b;
      ok = (n < 3000);
   endtask

   task automatic dev_transfer(input int n_edges, input bit ack, input int glitch_edge,
                               output logic [10:0] frame);
      int n;
      frame = '0;
      n = 0;
      while (!(ps2_data_oe === 1'b1 && ps2_clock_oe === 1'b0) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) return;
      for (int k = 1; k <= n_edges; k++) begin
         for (int c = 0; c < HALF; c++) begin
            @(negedge clk);
            dev_clk_low = (k == glitch_edge && c >= 5 && c < 8);
            if (k <= 10 && c == 30) frame[k-1] = ps2_data;
            if (k == 11 && c == 15) frame[10] = ps2_data;
            if (k == 11 && c == 20 && ack) dev_data_low = 1'b1;
         end
         dev_clk_low = 1'b1;
         repeat (HALF) @(negedge clk);
      end
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_done(input int base, input int budget, output bit seen);
      int n;
      n = 0;
      while (done_cnt == base && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      seen = (done_cnt != base);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({tx_ready, busy} !== 2'b10) $display("FAIL reset_ready: got %b expected 10", {tx_ready, busy});
      else passes++;
      checks++;
      if ({ps2_clock_oe, ps2_data_oe} !== 2'b00) $display("FAIL reset_oe: got %b expected 00", {ps2_clock_oe, ps2_data_oe});
      else passes++;
      checks++;
      if ({done, ack_ok, error} !== 3'b000) $display("FAIL reset_status: got %b expected 000", {done, ack_ok, error});
      else passes++;
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      $display("reset released");
   endtask

   task automatic test_send_ed();
      int base_d, base_e;
      logic [10:0] frame;
      bit ok, seen;
      base_d = done_cnt;
      base_e = err_cnt;
      send_byte(8'hED, ok);
      checks++;
      if (!ok) $display("FAIL ed_accept: got not-accepted expected accepted");
      else passes++;
      dev_transfer(11, 1'b1, 0, frame);
      checks++;
      if (frame !== 11'h7DA) $display("FAIL ed_frame: got %03h expected 7da", frame);
      else passes++;
      wait_done(base_d, 200, seen);
      checks++;
      if (!seen) $display("FAIL ed_done: got no done expected done");
      else passes++;
      checks++;
      if (done_ack !== 1'b1) $display("FAIL ed_ack: got %b expected 1", done_ack);
      else passes++;
      checks++;
      if (done_err !== 1'b0 || err_cnt != base_e) $display("FAIL ed_error: got %b/%0d expected 0/%0d", done_err, err_cnt, base_e);
      else passes++;
      repeat (5) @(negedge clk);
      checks++;
      if ({ack_ok, tx_ready} !== 2'b11) $display("FAIL ed_hold: got %b expected 11", {ack_ok, tx_ready});
      else passes++;
      $display("send 0xED frame=%03h ack_ok=%b", frame, done_ack);
   endtask

   task automatic test_inhibit_ff();
      int base_d, n;
      logic [10:0] frame;
      bit ok, seen;
      base_d = done_cnt;
      send_byte(8'hFF, ok);
      checks++;
      if (!ok) $display("FAIL ff_accept: got not-accepted expected accepted");
      else passes++;
      // a second byte offered while busy must be ignored
      tx_data  = 8'h00;
      tx_valid = 1'b1;
      checks++;
      if ({ps2_clock_oe, tx_ready, busy} !== 3'b101) $display("FAIL ff_first_cycle: got %b expected 101", {ps2_clock_oe, tx_ready, busy});
      else passes++;
      n = 0;
      while (ps2_data_oe !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != INH || ps2_clock_oe !== 1'b1) $display("FAIL ff_inhibit_len: got %0d cycles clk_oe=%b expected %0d cycles clk_oe=1", n, ps2_clock_oe, INH);
      else passes++;
      @(negedge clk);
      checks++;
      if ({ps2_clock_oe, ps2_data_oe} !== 2'b01) $display("FAIL ff_release: got %b expected 01", {ps2_clock_oe, ps2_data_oe});
      else passes++;
      tx_valid = 1'b0;
      dev_transfer(11, 1'b1, 0, frame);
      checks++;
      if (frame !== 11'h7FE) $display("FAIL ff_frame: got %03h expected 7fe", frame);
      else passes++;
      wait_done(base_d, 200, seen);
      checks++;
      if (!seen || tx_ready !== 1'b0 || done_ack !== 1'b1) $display("FAIL ff_done: got seen=%b ready=%b ack=%b expected 1 0 1", seen, tx_ready, done_ack);
      else passes++;
      @(negedge clk);
      checks++;
      if ({tx_ready, busy} !== 2'b10) $display("FAIL ff_ready_after: got %b expected 10", {tx_ready, busy});
      else passes++;
      repeat (20) @(negedge clk);
      checks++;
      if (done_cnt != base_d + 1) $display("FAIL ff_single_done: got %0d expected %0d", done_cnt, base_d + 1);
      else passes++;
      $display("send 0xFF frame=%03h inhibit=%0d", frame, n);
   endtask

   task automatic test_nack();
      int base_d, base_e;
      logic [10:0] frame;
      bit ok, seen;
      base_d = done_cnt;
      base_e = err_cnt;
      send_byte(8'h01, ok);
      checks++;
      if (!ok) $display("FAIL nack_accept: got not-accepted expected accepted");
      else passes++;
`ifndef PS2_HOST_TX_RETRY_EN
      dev_transfer(11, 1'b0, 0, frame);
      checks++;
      if (frame !== 11'h402) $display("FAIL nack_frame: got %03h expected 402", frame);
      else passes++;
      wait_done(base_d, 200, seen);
      checks++;
      if (!seen || done_ack !== 1'b0 || done_err !== 1'b1) $display("FAIL nack_done: got seen=%b ack=%b err=%b expected 1 0 1", seen, done_ack, done_err);
      else passes++;
      checks++;
      if (err_cnt != base_e + 1) $display("FAIL nack_error_count: got %0d expected %0d", err_cnt, base_e + 1);
      else passes++;
      repeat (3) @(negedge clk);
      checks++;
      if (ack_ok !== 1'b0) $display("FAIL nack_hold: got %b expected 0", ack_ok);
      else passes++;
      $display("send 0x01 frame=%03h nack reported", frame);
`else
      for (int a = 0; a < 3; a++) begin
         dev_transfer(11, (a == 2), 0, frame);
         checks++;
         if (frame !== 11'h402) $display("FAIL retry_frame%0d: got %03h expected 402", a, frame);
         else passes++;
         if (a < 2) begin
            repeat (30) @(negedge clk);
            #1;
            checks++;
            if (done_cnt != base_d || busy !== 1'b1) $display("FAIL retry_quiet%0d: got done=%0d busy=%b expected %0d 1", a, done_cnt, busy, base_d);
            else passes++;
         end
      end
      wait_done(base_d, 200, seen);
      checks++;
      if (!seen || done_ack !== 1'b1 || done_err !== 1'b0) $display("FAIL retry_done: got seen=%b ack=%b err=%b expected 1 1 0", seen, done_ack, done_err);
      else passes++;
      checks++;
      if (err_cnt != base_e) $display("FAIL retry_error_count: got %0d expected %0d", err_cnt, base_e);
      else passes++;
      $display("send 0x01 with retries frame=%03h ack_ok=%b", frame, done_ack);
`endif
   endtask

   task automatic test_timeout();
      int n, m, exp_m;
      bit ok;
`ifdef PS2_HOST_TX_RETRY_EN
      exp_m = 3 * TO + 2 * (INH + 1);
`else
      exp_m = TO;
`endif
      send_byte(8'h33, ok);
      checks++;
      if (!ok) $display("FAIL to_accept: got not-accepted expected accepted");
      else passes++;
      n = 0;
      while (!(ps2_clock_oe === 1'b0 && ps2_data_oe === 1'b1) && n < 500) begin
         @(negedge clk);
         n++;
      end
      m = 0;
      while (done !== 1'b1 && m < 4000) begin
         @(negedge clk);
         m++;
      end
      checks++;
      if (m != exp_m) $display("FAIL to_latency: got %0d expected %0d", m, exp_m);
      else passes++;
      checks++;
      if ({error, ack_ok} !== 2'b10) $display("FAIL to_status: got %b expected 10", {error, ack_ok});
      else passes++;
      checks++;
      if ({ps2_clock_oe, ps2_data_oe} !== 2'b00) $display("FAIL to_oe: got %b expected 00", {ps2_clock_oe, ps2_data_oe});
      else passes++;
      @(negedge clk);
      checks++;
      if (tx_ready !== 1'b1) $display("FAIL to_ready: got %b expected 1", tx_ready);
      else passes++;
      $display("send 0x33 timeout after %0d cycles", m);
   endtask

   task automatic test_glitch();
      int base_d;
      logic [10:0] frame;
      bit ok, seen;
      base_d = done_cnt;
      send_byte(8'h56, ok);
      checks++;
      if (!ok) $display("FAIL glitch_accept: got not-accepted expected accepted");
      else passes++;
      dev_transfer(11, 1'b1, 5, frame);
      checks++;
      if (frame !== 11'h6AC) $display("FAIL glitch_frame: got %03h expected 6ac", frame);
      else passes++;
      wait_done(base_d, 200, seen);
      checks++;
      if (!seen || done_ack !== 1'b1) $display("FAIL glitch_done: got seen=%b ack=%b expected 1 1", seen, done_ack);
      else passes++;
      $display("send 0x56 with clock glitch frame=%03h", frame);
   endtask

   task automatic test_reset_mid();
      int base_d, base_e;
      logic [10:0] frame;
      bit ok, seen;
      base_d = done_cnt;
      base_e = err_cnt;
      send_byte(8'h00, ok);
      dev_transfer(4, 1'b0, 0, frame);
      checks++;
      if (ps2_data_oe !== 1'b1) $display("FAIL mid_pre_oe: got %b expected 1", ps2_data_oe);
      else passes++;
      @(negedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({ps2_clock_oe, ps2_data_oe, tx_ready} !== 3'b001) $display("FAIL mid_async_release: got %b expected 001", {ps2_clock_oe, ps2_data_oe, tx_ready});
      else passes++;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (30) @(negedge clk);
      #1;
      checks++;
      if (done_cnt != base_d || err_cnt != base_e) $display("FAIL mid_no_report: got %0d/%0d expected %0d/%0d", done_cnt, err_cnt, base_d, base_e);
      else passes++;
      send_byte(8'h12, ok);
      checks++;
      if (!ok) $display("FAIL mid_reaccept: got not-accepted expected accepted");
      else passes++;
      dev_transfer(11, 1'b1, 0, frame);
      checks++;
      if (frame !== 11'h624) $display("FAIL mid_frame: got %03h expected 624", frame);
      else passes++;
      wait_done(base_d, 200, seen);
      checks++;
      if (!seen || done_ack !== 1'b1) $display("FAIL mid_done: got seen=%b ack=%b expected 1 1", seen, done_ack);
      else passes++;
      $display("reset mid-transfer then send 0x12 frame=%03h", frame);
   endtask

   initial begin
      test_reset();
      test_send_ed();
      test_inhibit_ff();
      test_nack();
      test_timeout();
      test_glitch();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
